// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: 8 ops, running XOR accumulator, valid/ready on both sides.
// Optional zero/parity result flags are built only when LU_FLAGS_EN is defined.
`timescale 1ns/1ps
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [CNT_W-1:0] ops_done
`ifdef LU_FLAGS_EN
  ,
  output logic             zero,
  output logic             parity
`endif
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NAND = 3'b011,
    OP_NOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOTA = 3'b110,
    OP_ACC  = 3'b111
  } op_e;

  logic             r_valid;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_ops;
  logic             w_accept;
  logic             w_is_acc;
  logic [WIDTH-1:0] w_res;
  op_e              w_op;

  assign w_op     = op_e'(op);
  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_is_acc = (w_op == OP_ACC);

  always_comb begin
    w_res = '0;
    case (w_op)
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_XOR:  w_res = a ^ b;
      OP_NAND: w_res = ~(a & b);
      OP_NOR:  w_res = ~(a | b);
      OP_XNOR: w_res = ~(a ^ b);
      OP_NOTA: w_res = ~a;
      OP_ACC:  w_res = r_acc ^ a ^ b;
      default: w_res = '0;
    endcase
  end

  // y holds its last value after the result is consumed; only out_valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_y     <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_y     <= w_res;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Clear takes priority over an ACC update landing on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (acc_clr) begin
      r_acc <= '0;
    end else if (w_accept && w_is_acc) begin
      r_acc <= w_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ops <= '0;
    end else if (r_valid && out_ready) begin
      r_ops <= r_ops + CNT_W'(1);
    end
  end

  assign out_valid = r_valid;
  assign y         = r_y;
  assign ops_done  = r_ops;

`ifdef LU_FLAGS_EN
  logic r_zero;
  logic r_parity;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero   <= 1'b0;
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_zero   <= (w_res == '0);
      r_parity <= ^w_res;
    end
  end

  assign zero   = r_zero;
  assign parity = r_parity;
`endif

endmodule
